// File: rtl/seq_sa_mult.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, valid/ready on both sides.
// Define SEQ_SA_MULT_SIGNED_EN for two's complement operands and product (default: unsigned).
module seq_sa_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [CW-1:0]        count_reg;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  assign acc_sum = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

`ifdef SEQ_SA_MULT_SIGNED_EN
  logic neg_reg;

  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign a_mag  = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
  assign b_mag  = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;
  assign result = neg_reg ? ({(2*WIDTH){1'b0}} - acc_sum) : acc_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_reg <= 1'b0;
    end else if (state_reg == IDLE && in_valid) begin
      neg_reg <= a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = acc_sum;
`endif

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (count_reg == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      p          <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
            mplier_reg <= b_mag;
            count_reg  <= '0;
          end
        end
        RUN: begin
          acc_reg    <= acc_sum;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + 1'b1;
          // p only changes here, so it holds the previous result until the next job lands.
          if (count_reg == LAST) p <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sa_mult.sv
// Randomised bench for seq_sa_mult (WIDTH=8) against an arithmetic reference model.
module tb_seq_sa_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           in_ready;
  logic           out_valid;
  logic [2*W-1:0] p;

  int n_checks = 0;
  int n_fail = 0;

  seq_sa_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SEQ_SA_MULT_SIGNED_EN
    logic signed [2*W-1:0] r;
    r = $signed(x) * $signed(y);
    return r;
`else
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
`endif
  endfunction

  // Wait (bounded) for out_valid from a negedge just after the accepting edge; returns edge count.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      check("in_ready_run", in_ready, 1'b0);
      in_valid = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Called at a negedge with the block idle.
  task automatic run_job(input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    logic [2*W-1:0] exp;
    int lat;
    exp = model(x, y);
    check("in_ready_idle", in_ready, 1'b1);
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    out_ready = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    wait_result(lat);
    check("latency", lat, W);
    check("out_valid", out_valid, 1'b1);
    check("product", p, exp);
    out_ready = 1'b0;
    repeat (hold) begin
      in_valid = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("p_hold", p, exp);
      check("out_valid_hold", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("out_valid_drain", out_valid, 1'b0);
    check("in_ready_drain", in_ready, 1'b1);
    check("p_after_drain", p, exp);
    out_ready = 1'b0;
    $display("job a=%0h b=%0h p=%0h exp=%0h latency=%0d hold=%0d", x, y, p, exp, lat, hold);
  endtask

  logic [W-1:0] da [10] = '{8'd13, 8'd255, 8'd0, 8'd200, 8'hFD, 8'h80, 8'h80, 8'd7, 8'd1, 8'h7F};
  logic [W-1:0] db [10] = '{8'd11, 8'd255, 8'd200, 8'd0, 8'd5, 8'h80, 8'h7F, 8'd6, 8'hFF, 8'h7F};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_p", p, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operands, including long backpressure on the first job.
    for (int i = 0; i < 10; i++) run_job(da[i], db[i], (i == 0) ? 20 : i % 3);

    // Reset in the middle of RUN, after four RUN edges.
    in_valid = 1'b1;
    a = W'($urandom);
    b = W'($urandom_range(1, 255));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b1);
    check("async_rst_p", p, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(8'd7, 8'd6, 2);

    // Back-to-back with in_valid held high: second job accepted on the edge after drain.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a = 8'd15;
    b = 8'd15;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("b2b_latency1", lat, W);
    check("b2b_p1", p, model(8'd15, 8'd15));
    a = 8'd9;
    b = 8'd10;
    @(posedge clk);
    @(negedge clk);
    check("b2b_in_ready_after_drain", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_second_accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("b2b_latency2", lat, W);
    check("b2b_p2", p, model(8'd9, 8'd10));
    $display("job back-to-back second p=%0h latency=%0d", p, lat);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle", in_ready, 1'b1);

    // Random jobs.
    for (int i = 0; i < 30; i++) run_job(W'($urandom), W'($urandom), $urandom_range(0, 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
